// File: rtl/frame_scoring_engine.sv
// frame_scoring_engine: per-frame overlap-pixel scoring with grade, combo streak and saturating total.
module frame_scoring_engine #(
    parameter int                 PIXEL_W       = 12,
    parameter logic [PIXEL_W-1:0] BG_COLOR      = 12'h000,
    parameter logic [PIXEL_W-1:0] SIL_COLOR     = 12'h0F0,
    parameter logic [PIXEL_W-1:0] PLAYER_COLOR  = 12'hFFF,
    parameter int                 PIX_PER_POINT = 16,
    parameter int                 PTS_W         = 12,
    parameter int                 OK_TH         = 4,
    parameter int                 GOOD_TH       = 16,
    parameter int                 PERFECT_TH    = 32,
    parameter int                 COMBO_W       = 8,
    parameter int                 COMBO_STEP    = 4,
    parameter int                 MAX_MULT      = 4,
    parameter int                 SCORE_W       = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_score,
    input  logic               counting,
    input  logic               pixel_valid,
    input  logic [PIXEL_W-1:0] pixel,
    input  logic               frame_end,
    output logic [SCORE_W-1:0] score,
    output logic [PTS_W-1:0]   frame_points,
    output logic [1:0]         grade,
    output logic [COMBO_W-1:0] combo,
    output logic               grade_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int SUB_W  = PIX_PER_POINT > 1 ? $clog2(PIX_PER_POINT) : 1;
    localparam int MULT_W = 3;
    localparam int PROD_W = PTS_W + MULT_W;
    localparam int SUM_W  = (SCORE_W > PROD_W ? SCORE_W : PROD_W) + 1;

    typedef enum logic [1:0] {IDLE, EVAL, ADD} state_t;

    state_t             state;
    logic [SUB_W-1:0]   sub_cnt, sub_next;
    logic [PTS_W-1:0]   pts_acc, pts_next, pts_cap;
    logic [1:0]         grade_n, grade_c;
    logic [COMBO_W-1:0] combo_n, combo_c;
    logic [MULT_W-1:0]  mult, mult_c;
    logic [PROD_W-1:0]  prod;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_sat;
    logic               overlap, pt_done;
    int                 mult_i;

    always_comb begin
        overlap   = counting && pixel_valid && pixel != BG_COLOR && pixel != SIL_COLOR && pixel != PLAYER_COLOR;
        pt_done   = overlap && sub_cnt == SUB_W'(PIX_PER_POINT - 1);
        sub_next  = overlap ? (pt_done ? '0 : sub_cnt + SUB_W'(1)) : sub_cnt;
        pts_next  = (pt_done && pts_acc != '1) ? pts_acc + PTS_W'(1) : pts_acc;
        grade_c   = pts_cap >= PTS_W'(PERFECT_TH) ? 2'd3 :
                    pts_cap >= PTS_W'(GOOD_TH)    ? 2'd2 :
                    pts_cap >= PTS_W'(OK_TH)      ? 2'd1 : 2'd0;
        combo_c   = grade_c[1] ? (combo == '1 ? combo : combo + COMBO_W'(1)) :
                    grade_c == 2'd0 ? '0 : combo;
        mult_i    = 1 + int'(combo_c) / COMBO_STEP;
        mult_c    = MULT_W'(mult_i > MAX_MULT ? MAX_MULT : mult_i);
        prod      = PROD_W'(pts_cap) * PROD_W'(mult);
        sum       = SUM_W'(score) + SUM_W'(prod);
        score_sat = sum[SUM_W-1:SCORE_W] != '0 ? '1 : sum[SCORE_W-1:0];
        busy      = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sub_cnt      <= '0;
            pts_acc      <= '0;
            pts_cap      <= '0;
            grade_n      <= '0;
            combo_n      <= '0;
            mult         <= '0;
            score        <= '0;
            frame_points <= '0;
            grade        <= '0;
            combo        <= '0;
            grade_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear_score) begin
            state        <= IDLE;
            sub_cnt      <= '0;
            pts_acc      <= '0;
            score        <= '0;
            frame_points <= '0;
            grade        <= '0;
            combo        <= '0;
            grade_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            grade_valid <= 1'b0;
            sub_cnt     <= sub_next;
            pts_acc     <= pts_next;
            if (frame_end && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (frame_end) begin
                    // the pixel arriving with frame_end still belongs to the closing frame
                    pts_cap <= pts_next;
                    pts_acc <= '0;
                    sub_cnt <= '0;
                    state   <= EVAL;
                end
                EVAL: begin
                    grade_n <= grade_c;
                    combo_n <= combo_c;
                    mult    <= mult_c;
                    state   <= ADD;
                end
                ADD: begin
                    score        <= score_sat;
                    grade        <= grade_n;
                    combo        <= combo_n;
                    frame_points <= pts_cap;
                    grade_valid  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
